// File: rtl/loader_dispatch_if.sv
// Loader-read, IMEM-write and accelerator-channel signals of the program-loader dispatcher.
interface loader_dispatch_if #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned IMEM_AW   = 10,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned MAX_WORDS = 32
);
    localparam int unsigned BUF_W = MAX_WORDS * WORD_W;

    logic               ld_rd;
    logic [ADDR_W-1:0]  ld_addr;
    logic               ld_valid;
    logic [WORD_W-1:0]  ld_data;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [WORD_W-1:0]  imem_wdata;
    logic [NUM_CH-1:0]  ch_we;
    logic [BUF_W-1:0]   ch_data;
    logic [6:0]         ch_len;
    logic [NUM_CH-1:0]  ch_ready;

    modport master (
        output ld_rd, ld_addr, imem_we, imem_addr, imem_wdata, ch_we, ch_data, ch_len,
        input  ld_valid, ld_data, ch_ready
    );

    modport slave (
        input  ld_rd, ld_addr, imem_we, imem_addr, imem_wdata, ch_we, ch_data, ch_len,
        output ld_valid, ld_data, ch_ready
    );
endinterface

// File: rtl/loader_dispatch.sv
// Program-loader dispatcher: copies instruction words into IMEM and packs
// opcode-tagged payloads into a wide buffer delivered to accelerator channels.
module loader_dispatch #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned IMEM_AW   = 10,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned MAX_WORDS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    loader_dispatch_if.master  bus,
    output logic               busy,
    output logic               cpu_start,
    output logic               err
);
    localparam int unsigned BUF_W = MAX_WORDS * WORD_W;
    localparam int unsigned LEN_W = 7;
    localparam int unsigned OP_W  = 5;
    localparam logic [OP_W-1:0]   OP_HALT  = 5'b11111;
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(WORD_W / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_PAY_REQ, S_PAY_WAIT, S_DELIVER, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               ld_rd_q, ld_rd_d;
    logic [ADDR_W-1:0]  ld_addr_q, ld_addr_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]  imem_wdata_q, imem_wdata_d;
    logic [NUM_CH-1:0]  ch_we_q, ch_we_d;
    logic [BUF_W-1:0]   pay_q, pay_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ch_k_q, ch_k_d;
    logic               busy_q, busy_d;
    logic               cpu_start_q, cpu_start_d;
    logic               err_q, err_d;

    logic [OP_W-1:0]    op;
    logic               is_halt;
    logic               is_ch;
    logic [5:0]         len_field;
    logic [LEN_W-1:0]   len_sel;
    logic               len_over;
    logic [LEN_W-1:0]   cnt_inc;

    // Word classification and length decode (0 encodes a full buffer)
    always_comb begin
        op        = bus.ld_data[WORD_W-1 -: OP_W];
        is_halt   = (op == OP_HALT);
        is_ch     = (op[4:2] == 3'b111) && !is_halt && (32'(op[1:0]) < NUM_CH);
        len_field = bus.ld_data[5:0];
        len_over  = 1'b0;
        if (len_field == 6'd0) begin
            len_sel = LEN_MAX;
        end else if (LEN_W'(len_field) > LEN_MAX) begin
            len_sel  = LEN_MAX;
            len_over = 1'b1;
        end else begin
            len_sel = LEN_W'(len_field);
        end
        cnt_inc = cnt_q + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ld_rd_q      <= 1'b0;
            ld_addr_q    <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            ch_we_q      <= '0;
            pay_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            ch_k_q       <= '0;
            busy_q       <= 1'b0;
            cpu_start_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_addr_q    <= ld_addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            ch_we_q      <= ch_we_d;
            pay_q        <= pay_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            ch_k_q       <= ch_k_d;
            busy_q       <= busy_d;
            cpu_start_q  <= cpu_start_d;
            err_q        <= err_d;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_d      = state_q;
        ld_addr_d    = ld_rd_q ? ld_addr_q + ADDR_INC : ld_addr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_we_q ? imem_addr_q + IMEM_AW'(1) : imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        pay_d        = pay_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        ch_k_d       = ch_k_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ld_addr_d   = '0;
                    imem_addr_d = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ:     state_d = S_WAIT;
            S_PAY_REQ: state_d = S_PAY_WAIT;
            S_WAIT: begin
                if (bus.ld_valid) begin
                    imem_we_d    = 1'b1;
                    imem_wdata_d = bus.ld_data;
                    if (is_halt) begin
                        state_d = S_DONE;
                    end else if (is_ch) begin
                        ch_k_d  = op[1:0];
                        len_d   = len_sel;
                        cnt_d   = '0;
                        pay_d   = '0;
                        err_d   = err_q | len_over;
                        state_d = S_PAY_REQ;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_PAY_WAIT: begin
                if (bus.ld_valid) begin
                    pay_d   = (pay_q << WORD_W) | BUF_W'(bus.ld_data);
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_DELIVER : S_PAY_REQ;
                end
            end
            S_DELIVER: begin
                // ch_we_q is one-hot on the selected channel, masking other readies
                if (|(bus.ch_ready & ch_we_q)) state_d = S_REQ;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        ld_rd_d     = (state_d == S_REQ) || (state_d == S_PAY_REQ);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        cpu_start_d = (state_d == S_DONE);
        ch_we_d     = (state_d == S_DELIVER) ? (NUM_CH'(1) << ch_k_d) : '0;
    end

    assign bus.ld_rd      = ld_rd_q;
    assign bus.ld_addr    = ld_addr_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.ch_we      = ch_we_q;
    assign bus.ch_data    = pay_q;
    assign bus.ch_len     = len_q;
    assign busy           = busy_q;
    assign cpu_start      = cpu_start_q;
    assign err            = err_q;
endmodule

// File: tb/tb_loader_dispatch.sv
// Directed scoreboard bench for loader_dispatch: loader memory model with
// configurable latency, per-channel ready backpressure and expected-result queues.
module tb_loader_dispatch;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned IMEM_AW   = 10;
    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned MAX_WORDS = 32;
    localparam int unsigned BUF_W     = MAX_WORDS * WORD_W;

    typedef struct {
        logic [IMEM_AW-1:0] addr;
        logic [WORD_W-1:0]  data;
    } imem_exp_t;

    typedef struct {
        logic [NUM_CH-1:0] we;
        logic [6:0]        len;
        logic [BUF_W-1:0]  data;
        int                hold;
        logic              err;
    } ch_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, cpu_start, err;

    always #5 clk = ~clk;

    loader_dispatch_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .IMEM_AW(IMEM_AW),
                         .NUM_CH(NUM_CH), .MAX_WORDS(MAX_WORDS)) bus ();

    loader_dispatch #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .IMEM_AW(IMEM_AW),
                      .NUM_CH(NUM_CH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .cpu_start (cpu_start),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] lmem [0:255];
    imem_exp_t imem_q[$];
    ch_exp_t   ch_q[$];

    int          lat = 1;
    bit          pend_active = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;
    logic [15:0] exp_addr = '0;
    bit          spur_en = 1'b0;
    logic [2:0]  rdy_ok = 3'b111;
    logic [2:0]  rdy_block = 3'b000;
    int          rdy_delay = 0;
    bit          in_deliv = 1'b0;
    int          deliv_cycles = 0;
    ch_exp_t     cur_ch;
    int          reads_seen = 0;
    int          cyc = 0;
    logic [BUF_W-1:0] d0, d1;

    task automatic check(input string tag, input logic [BUF_W-1:0] obs, input logic [BUF_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero();
        check("rst_ld_rd",      BUF_W'(bus.ld_rd),      '0);
        check("rst_ld_addr",    BUF_W'(bus.ld_addr),    '0);
        check("rst_imem_we",    BUF_W'(bus.imem_we),    '0);
        check("rst_imem_addr",  BUF_W'(bus.imem_addr),  '0);
        check("rst_imem_wdata", BUF_W'(bus.imem_wdata), '0);
        check("rst_ch_we",      BUF_W'(bus.ch_we),      '0);
        check("rst_ch_data",    bus.ch_data,            '0);
        check("rst_ch_len",     BUF_W'(bus.ch_len),     '0);
        check("rst_busy",       BUF_W'(busy),           '0);
        check("rst_cpu_start",  BUF_W'(cpu_start),      '0);
        check("rst_err",        BUF_W'(err),            '0);
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs for the next rising edge
    task automatic step();
        imem_exp_t ie;
        @(negedge clk);
        if (bus.imem_we === 1'b1) begin
            check("imem_expected", BUF_W'(imem_q.size() != 0), BUF_W'(1'b1));
            if (imem_q.size() != 0) begin
                ie = imem_q.pop_front();
                check("imem_addr", BUF_W'(bus.imem_addr), BUF_W'(ie.addr));
                check("imem_data", BUF_W'(bus.imem_wdata), BUF_W'(ie.data));
                check("cpu_start_with_write", BUF_W'(cpu_start), BUF_W'(ie.data[15:11] == 5'b11111));
            end
        end
        if (bus.ch_we !== '0) begin
            if (!in_deliv) begin
                check("ch_expected", BUF_W'(ch_q.size() != 0), BUF_W'(1'b1));
                if (ch_q.size() != 0) cur_ch = ch_q.pop_front();
                in_deliv = 1'b1;
                deliv_cycles = 0;
            end
            deliv_cycles++;
            check("ch_we",   BUF_W'(bus.ch_we),  BUF_W'(cur_ch.we));
            check("ch_len",  BUF_W'(bus.ch_len), BUF_W'(cur_ch.len));
            check("ch_data", bus.ch_data,        cur_ch.data);
            check("ch_err",  BUF_W'(err),        BUF_W'(cur_ch.err));
        end else if (in_deliv) begin
            check("ch_hold_cycles", BUF_W'(deliv_cycles), BUF_W'(cur_ch.hold));
            in_deliv = 1'b0;
        end

        bus.ld_valid = 1'b0;
        if (pend_active) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = lmem[pend_addr[8:1]];
                pend_active  = 1'b0;
            end
        end else if (spur_en && bus.ch_we !== '0) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 16'hDEAD;
        end
        if (bus.ld_rd === 1'b1) begin
            check("single_outstanding", BUF_W'(pend_active), '0);
            check("ld_addr", BUF_W'(bus.ld_addr), BUF_W'(exp_addr));
            check("no_rd_in_deliver", BUF_W'(bus.ch_we), '0);
            check("no_rd_in_done", BUF_W'(cpu_start), '0);
            exp_addr    = exp_addr + 16'd2;
            pend_active = 1'b1;
            pend_cnt    = lat;
            pend_addr   = bus.ld_addr;
            reads_seen++;
        end

        if (bus.ch_we !== '0 && rdy_delay > 0) begin
            bus.ch_ready = rdy_block;
            rdy_delay--;
        end else begin
            bus.ch_ready = rdy_ok;
        end
    endtask

    // Asynchronous reset; outputs must clear without waiting for a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ch_ready = '0;
        imem_q.delete();
        ch_q.delete();
        pend_active = 1'b0;
        in_deliv    = 1'b0;
        spur_en     = 1'b0;
        rdy_delay   = 0;
        lat         = 1;
        #1 check_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_addr   = '0;
        reads_seen = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) lmem[i] = '0;
    endtask

    task automatic push_imem(input logic [IMEM_AW-1:0] a, input logic [WORD_W-1:0] w);
        imem_exp_t e;
        e.addr = a;
        e.data = w;
        imem_q.push_back(e);
    endtask

    task automatic push_ch(input logic [NUM_CH-1:0] we, input logic [6:0] len,
                           input logic [BUF_W-1:0] data, input int hold, input logic e);
        ch_exp_t c;
        c.we = we; c.len = len; c.data = data; c.hold = hold; c.err = e;
        ch_q.push_back(c);
    endtask

    // Pulse start, run to HALT within a cycle budget, then confirm DONE is sticky
    task automatic run_prog(input int budget, output int cycles);
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 1;
        while (cpu_start !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        check("halt_reached", BUF_W'(cpu_start), BUF_W'(1'b1));
        check("busy_after_halt", BUF_W'(busy), '0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        check("imem_queue_drained", BUF_W'(imem_q.size()), '0);
        check("ch_queue_drained", BUF_W'(ch_q.size()), '0);
        check("cpu_start_sticky", BUF_W'(cpu_start), BUF_W'(1'b1));
    endtask

    task automatic load_plain();
        clear_mem();
        lmem[0] = 16'h1234;
        lmem[1] = 16'h5678;
        lmem[2] = 16'hF800;
        push_imem(10'd0, 16'h1234);
        push_imem(10'd1, 16'h5678);
        push_imem(10'd2, 16'hF800);
    endtask

    initial begin
        do_reset();

        // Ordinary program, 1-cycle latency: two cycles per word
        load_plain();
        rdy_ok = 3'b111;
        run_prog(50, cyc);
        check("plain_cycles", BUF_W'(cyc), BUF_W'(7));
        check("plain_reads", BUF_W'(reads_seen), BUF_W'(3));
        check("plain_err", BUF_W'(err), '0);

        // Hash payload with ready already high
        do_reset();
        clear_mem();
        lmem[0] = 16'hE004;
        lmem[1] = 16'hAAAA; lmem[2] = 16'hBBBB; lmem[3] = 16'hCCCC; lmem[4] = 16'hDDDD;
        lmem[5] = 16'hF800;
        push_imem(10'd0, 16'hE004);
        push_imem(10'd1, 16'hF800);
        push_ch(3'b001, 7'd4, BUF_W'(64'hAAAA_BBBB_CCCC_DDDD), 1, 1'b0);
        rdy_ok = 3'b001;
        run_prog(100, cyc);
        check("hash_reads", BUF_W'(reads_seen), BUF_W'(6));

        // Encrypt payload held off for 5 cycles; other channels ready meanwhile
        do_reset();
        clear_mem();
        lmem[0] = 16'hE802; lmem[1] = 16'h0001; lmem[2] = 16'h0002; lmem[3] = 16'hF800;
        push_imem(10'd0, 16'hE802);
        push_imem(10'd1, 16'hF800);
        push_ch(3'b010, 7'd2, BUF_W'(32'h0001_0002), 6, 1'b0);
        rdy_ok = 3'b010;
        rdy_block = 3'b101;
        rdy_delay = 5;
        run_prog(100, cyc);

        // Length 0 on decrypt, then an over-long hash length clamped with err
        do_reset();
        clear_mem();
        d0 = '0;
        d1 = '0;
        lmem[0] = 16'hF000;
        for (int i = 0; i < 32; i++) begin
            lmem[1 + i] = 16'h0100 + 16'(i);
            d0 = (d0 << 16) | BUF_W'(16'h0100 + 16'(i));
        end
        lmem[33] = 16'hE03F;
        for (int i = 0; i < 32; i++) begin
            lmem[34 + i] = 16'h2000 + 16'(i);
            d1 = (d1 << 16) | BUF_W'(16'h2000 + 16'(i));
        end
        lmem[66] = 16'hF800;
        push_imem(10'd0, 16'hF000);
        push_imem(10'd1, 16'hE03F);
        push_imem(10'd2, 16'hF800);
        push_ch(3'b100, 7'd32, d0, 1, 1'b0);
        push_ch(3'b001, 7'd32, d1, 1, 1'b1);
        rdy_ok = 3'b111;
        run_prog(400, cyc);
        check("clamp_err_sticky", BUF_W'(err), BUF_W'(1'b1));
        check("clamp_first_word", BUF_W'(d0[BUF_W-1 -: 16]), BUF_W'(16'h0100));

        // 3-cycle latency with stray ld_valid pulses during delivery
        do_reset();
        clear_mem();
        lat = 3;
        spur_en = 1'b1;
        lmem[0] = 16'hE401; lmem[1] = 16'h5A5A; lmem[2] = 16'h1111; lmem[3] = 16'hF800;
        push_imem(10'd0, 16'hE401);
        push_imem(10'd1, 16'h1111);
        push_imem(10'd2, 16'hF800);
        push_ch(3'b001, 7'd1, BUF_W'(16'h5A5A), 3, 1'b0);
        rdy_ok = 3'b001;
        rdy_block = 3'b000;
        rdy_delay = 2;
        run_prog(100, cyc);

        // Reset after 2 of 4 payload words, then a clean reload from address 0
        do_reset();
        clear_mem();
        lmem[0] = 16'hE004;
        lmem[1] = 16'h0011; lmem[2] = 16'h0022; lmem[3] = 16'h0033; lmem[4] = 16'h0044;
        lmem[5] = 16'hF800;
        push_imem(10'd0, 16'hE004);
        rdy_ok = 3'b001;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (reads_seen < 4 && cyc < 50) begin
            step();
            cyc++;
        end
        check("mid_payload_reached", BUF_W'(reads_seen), BUF_W'(4));
        check("mid_payload_busy", BUF_W'(busy), BUF_W'(1'b1));
        #2;
        do_reset();
        load_plain();
        rdy_ok = 3'b111;
        run_prog(50, cyc);
        check("reload_cycles", BUF_W'(cyc), BUF_W'(7));
        check("reload_err", BUF_W'(err), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/loader_dispatch.md
# loader_dispatch

Parametrised program-loader dispatcher between the SPART program loader memory and the CPU/accelerator BRAMs. It fetches words from the loader and writes ordinary instruction words into IMEM. Payload-opcode words start a variable-length payload, which is packed into a wide buffer and delivered to one of NUM_CH accelerator channels (hash, encrypt, decrypt, …) with a ready handshake. On HALT it writes the HALT word to IMEM and raises cpu_start.

## Interface
Parameters:
- WORD_W, 16, loader word width; opcode is ld_data[WORD_W-1 -: 5], length field is ld_data[5:0]
- ADDR_W, 16, loader byte-address width
- IMEM_AW, 10, IMEM word-address width
- NUM_CH, 3, payload channels, 1..3; channel k opcode = 5'b11100 + k
- MAX_WORDS, 32, max payload words, 1..64; buffer width BUF_W = MAX_WORDS*WORD_W

Ports (reset rst_n is asynchronous, active-low; clock is clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse, begins loading at byte address 0; honoured only in IDLE
- ld_rd  out  1  one-cycle read request
- ld_addr  out  ADDR_W  byte address of request
- ld_valid  in  1  read data valid (≥1 cycle after ld_rd)
- ld_data  in  WORD_W  read data
- imem_we  out  1  IMEM write strobe
- imem_addr  out  IMEM_AW  IMEM word address
- imem_wdata  out  WORD_W  IMEM write data
- ch_we  out  NUM_CH  one-hot channel write request
- ch_data  out  BUF_W  packed payload
- ch_len  out  7  payload word count, 1..MAX_WORDS
- ch_ready  in  NUM_CH  per-channel accept
- busy  out  1  high in any state other than IDLE/DONE
- cpu_start  out  1  high in DONE
- err  out  1  sticky length-clamp error

## Operation
- States: IDLE, REQ, WAIT, PAY_REQ, PAY_WAIT, DELIVER, DONE.
- IDLE: on start, clear ld_addr and imem_addr, go to REQ.
- REQ/PAY_REQ: assert ld_rd with ld_addr for one cycle, go to WAIT/PAY_WAIT.
  - ld_addr increments by WORD_W/8 after each request.
  - ld_addr wraps modulo 2^ADDR_W.
- WAIT, on ld_valid, classifies the word:
  - ordinary (opcode not a channel code, not 5'b11111): write to IMEM, go to REQ.
  - channel k (k < NUM_CH): write to IMEM, latch k, latch length n, clear buffer, go to PAY_REQ.
    - Length n = ld_data[5:0]; 0 means MAX_WORDS.
    - n > MAX_WORDS is clamped to MAX_WORDS and sets err.
  - opcode 5'b11111 (HALT): write to IMEM, go to DONE.
  - Codes 5'b11100+k with k ≥ NUM_CH are ordinary instructions.
- PAY_WAIT, on ld_valid, shifts the word in: buf <= {buf[BUF_W-WORD_W-1:0], ld_data}. Payload words are never written to IMEM.
  - After n words, go to DELIVER; otherwise go to PAY_REQ.
  - Result: first word in bits [n*WORD_W-1 -: WORD_W], last word in [WORD_W-1:0], bits above n*WORD_W zero.
- DELIVER: hold ch_we[k]=1, ch_data and ch_len=n stable. Leave for REQ on the clock edge where ch_ready[k]=1. ch_ready for other channels is ignored.
- DONE: cpu_start=1, no further reads. Sticky until reset; start ignored.
- imem_addr increments by 1 after each IMEM write, wrapping modulo 2^IMEM_AW.
- ld_valid outside WAIT/PAY_WAIT is ignored. At most one read is outstanding.
- err is cleared only by reset.

## Timing
- Reset: all outputs 0 (ld_addr, imem_addr, ch_data, ch_len, ch_we, busy, cpu_start, err); state IDLE. Assertion mid-operation aborts immediately. No partial delivery; ch_we drops asynchronously.
- Outputs are registered.
- start→ld_rd: 1 cycle.
- ld_valid sampled in WAIT → imem_we high for exactly 1 cycle, next cycle. ld_rd for the following word is in that same cycle.
- Back-to-back with 1-cycle loader latency: 2 cycles per word.
- Last payload word sampled → ch_we high next cycle.
- ch_ready already high → ch_we lasts 1 cycle, then ld_rd the following cycle.
- HALT word sampled → imem_we and cpu_start rise in the same next cycle.

## Test plan
- Ordinary program: words 0x1234, 0x5678, 0xF800 (HALT) with 1-cycle latency → IMEM[0..2] = 0x1234, 0x5678, 0xF800; ld_addr sequence 0, 2, 4; cpu_start=1 after the third imem_we; busy=0.
- Hash payload: 0xE004 followed by 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD, ch_ready[0] tied high → ch_we=3'b001 for 1 cycle; ch_len=4; ch_data[63:0]=0xAAAABBBBCCCCDDDD, upper bits 0; only 0xE004 written to IMEM.
- Backpressure: encrypt payload 0xE802 with words 0x0001, 0x0002, ch_ready[1] low for 5 cycles → ch_we=3'b010 held 6 cycles, ch_data stable; no ld_rd until accepted.
- Length 0 / clamp: 0xF000 (decrypt, n=0) → 32 words packed, ch_len=32. 0xE03F with MAX_WORDS=32 → err=1, ch_len=32.
- Variable latency and stray data: ld_valid 3 cycles after each ld_rd, plus a spurious ld_valid in DELIVER → spurious ignored; correct IMEM contents.
- Reset mid-payload after 2 of 4 words → all outputs 0 at once; a new start reloads from address 0 cleanly.
